reduce_buffer_drain: RTL and testbench
======================================

# reduce_buffer_drain

- Two-poly reduce buffer between the cross-add last stage and the next pipeline stage.
- Captures the stage's write stream (per-poly mod-Q sums, write address, write enable) into an internal BRAM during a fill phase.
- Once all 2^n entries are written, drains them in address order 0..N-1 to the downstream consumer over a valid/ready handshake.
- Provides one-shot done and error pulses for the top-level controller.

## Interface
- DATA_WIDTH, 64, width of one poly word
- ADDR_WIDTH, 12, buffer depth is 2^ADDR_WIDTH entries
- COMMON_BRAM_LATENCY, 1, BRAM read latency in cycles
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  one-cycle pulse to begin a fill; honoured only in IDLE
- i_n  in  LEVEL_WIDTH  log2 of the entry count N; sampled on accepted i_start
- i_data_rb  in  N_POLY×DATA_WIDTH  write data; [0] holds A+C mod Q0, [1] holds B+D mod Q1
- i_addr_rb  in  ADDR_WIDTH  write address
- i_we_rb  in  1  write enable
- o_data  out  N_POLY×DATA_WIDTH  drained data
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accept; a beat transfers when o_valid & i_ready
- o_last  out  1  high with the beat for address N-1
- o_busy  out  1  high in FILL, DRAIN and DONE
- o_done  out  1  one-cycle pulse after the final beat transfers
- o_err  out  1  one-cycle pulse on a protocol violation

## Operation
- N = 1 << min(i_n, ADDR_WIDTH); i_n = 0 gives N = 1. N is latched on the accepted i_start.
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - i_start → FILL; clear write count wcnt.
  - i_we_rb in IDLE without i_start → write dropped, o_err pulses.
- FILL:
  - i_we_rb with i_addr_rb < N → store both poly words, wcnt++.
  - i_we_rb with i_addr_rb ≥ N → dropped, not counted, o_err pulses.
  - Duplicate addresses are counted: last write wins, and wcnt counts writes, not unique addresses.
  - When wcnt reaches N → DRAIN; read pointer rptr = 0.
- DRAIN:
  - Issue a BRAM read at rptr when rptr < N and FIFO occupancy + in-flight reads < FIFO depth (COMMON_BRAM_LATENCY+2).
  - Read data pushes into the output FIFO. o_data/o_valid come from the FIFO head.
  - o_last is set on the entry tagged rptr = N-1.
  - Handshake on the last beat → DONE.
- DONE: o_done = 1 for exactly one cycle, then unconditionally → IDLE.
- i_start outside IDLE → ignored, o_err pulses.
- i_we_rb in DRAIN or DONE → ignored, o_err pulses; buffer contents are not modified.
- o_data is held stable while o_valid & !i_ready. o_valid never drops without a handshake.
- Buffer contents are not cleared by reset or completion. Every drain reads only addresses written in the current fill.

## Timing
- Reset (rst_n low at an edge): state = IDLE, wcnt = rptr = 0, FIFO empty, in-flight reads discarded.
- Reset values of outputs: o_data = 0, o_valid = 0, o_last = 0, o_busy = 0, o_done = 0, o_err = 0.
- Reset mid-fill or mid-drain aborts the run; no o_done is produced.
- i_start and i_we_rb in the same IDLE cycle: the write is accepted and counted as the first of the fill.
- Final write sampled at cycle c:
  - c+1: state = DRAIN, read of address 0 issued.
  - c+1+COMMON_BRAM_LATENCY: data enters the FIFO.
  - c+2+COMMON_BRAM_LATENCY: o_valid = 1.
- With i_ready held high, throughput is one beat per cycle with no bubbles. Last beat at c+1+COMMON_BRAM_LATENCY+N.
- o_done is asserted the cycle after the last handshake. o_busy falls the cycle after o_done.
- A new i_start is accepted one cycle after o_done at the earliest.
- o_err is registered: it asserts the cycle after the offending input.

## Structure
- The shared package addx_pkg holds:
  - N_POLY = 2 and LEVEL_WIDTH = 4, common with the adjacent stages;
  - the state enum (IDLE, FILL, DRAIN, DONE);
  - the typedef for the N_POLY×DATA_WIDTH word.
- The buffer is an inferred simple dual-port BRAM (one write port, one read port) in the top module, with registered read data per COMMON_BRAM_LATENCY.
- One sub-module, rb_skid_fifo: a synchronous FIFO of depth COMMON_BRAM_LATENCY+2, entry = data + last flag. Its outputs drive o_data, o_valid and o_last directly.

## Test plan
- Basic fill/drain:
  - Stimulus: i_n = 3, i_start, then 8 writes to addresses 7..0 with data[0] = addr, data[1] = addr+100, i_ready = 1.
  - Required response: first o_valid 3 cycles after the last write; beats in address order 0..7 with data[1] = 100..107; o_last on beat 7; o_done one cycle later.
- Backpressure:
  - Stimulus: i_n = 4, i_ready toggling 1,0,0,1.
  - Required response: 16 beats in order, o_data stable during stalls, no loss or duplicates, FIFO never overflows.
- Errors:
  - Stimulus: i_n = 2, write to address 5, then a write in IDLE before i_start.
  - Required response: o_err pulses each time, wcnt unchanged; fill still needs 4 valid writes.
- Edge sizes:
  - Stimulus: i_n = 0 with one write to address 0; i_n = 15 with ADDR_WIDTH = 12.
  - Required response: i_n = 0 drains 1 beat with o_last = 1; i_n = 15 clamps N to 4096 and o_last lands on address 4095.
- Reset mid-drain:
  - Stimulus: deassert rst_n after beat 2 of 8, release, new i_start with i_n = 1 and 2 writes.
  - Required response: all outputs 0 during reset, no o_done for the aborted run, clean 2-beat drain afterwards.
- Protocol:
  - Stimulus: i_start and i_we_rb in DRAIN.
  - Required response: o_err pulse; drained data unaffected.

Source files
------------

// File: rtl/addx_pkg.sv
// addx_pkg: definitions shared by the cross-add stages and the reduce buffer.
//   N_POLY          number of polys carried per word
//   LEVEL_WIDTH     width of the log2 entry-count field (i_n)
//   rb_state_t      reduce-buffer control states
//   poly_word_t     one N_POLY x POLY_DATA_WIDTH word at the default data width
package addx_pkg;

    localparam int unsigned N_POLY          = 2;
    localparam int unsigned LEVEL_WIDTH     = 4;
    localparam int unsigned POLY_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } rb_state_t;

    typedef logic [N_POLY-1:0][POLY_DATA_WIDTH-1:0] poly_word_t;

endpackage

// File: rtl/rb_skid_fifo.sv
// rb_skid_fifo: small synchronous FIFO holding drained words plus a last flag.
//   clk, rst_n     clock, synchronous active-low reset (pointers/count only)
//   i_push         write i_data/i_last this cycle (caller guarantees room)
//   i_ready        downstream accept; head pops when o_valid & i_ready
//   o_data/o_last  head entry, forced to zero while empty
//   o_valid        FIFO not empty
//   o_count        current occupancy, used by the caller for read credits
module rb_skid_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] mem_last;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;

    assign o_valid = (count != '0);
    assign pop     = o_valid & i_ready;
    assign o_count = count;
    assign o_data  = o_valid ? mem_data[rd_ptr] : '0;
    assign o_last  = o_valid & mem_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({i_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            mem_data[wr_ptr] <= i_data;
            mem_last[wr_ptr] <= i_last;
        end
    end

endmodule

// File: rtl/reduce_buffer_drain.sv
// reduce_buffer_drain: two-poly reduce buffer. Captures the cross-add write
// stream into a BRAM, then drains entries 0..N-1 over valid/ready.
//   clk, rst_n              clock, synchronous active-low reset
//   i_start, i_n            begin a fill of N = 1 << min(i_n, ADDR_WIDTH) entries
//   i_data_rb/i_addr_rb/i_we_rb   write stream from the last cross-add stage
//   o_data/o_valid/o_last, i_ready   drain stream towards the next stage
//   o_busy                  high in FILL, DRAIN and DONE
//   o_done, o_err           one-cycle completion / protocol-violation pulses
module reduce_buffer_drain
    import addx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 64,
    parameter int unsigned ADDR_WIDTH          = 12,
    parameter int unsigned COMMON_BRAM_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_start,
    input  logic [LEVEL_WIDTH-1:0]            i_n,
    input  logic [N_POLY-1:0][DATA_WIDTH-1:0] i_data_rb,
    input  logic [ADDR_WIDTH-1:0]             i_addr_rb,
    input  logic                              i_we_rb,
    output logic [N_POLY-1:0][DATA_WIDTH-1:0] o_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic                              o_last,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_err
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH  = COMMON_BRAM_LATENCY + 2;
    localparam int unsigned WORD_W = N_POLY * DATA_WIDTH;
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W  = $clog2(COMMON_BRAM_LATENCY + 1);

    typedef logic [N_POLY-1:0][DATA_WIDTH-1:0] word_t;

    rb_state_t         state, state_nxt;
    logic [CNT_W-1:0]  n_req, n_lat, n_eff;
    logic [CNT_W-1:0]  wcnt, wcnt_inc, rptr;
    logic              addr_ok, wr_en, fill_full, err_next, err_q, rd_en;
    logic              beat_last;
    logic [FCNT_W-1:0] fifo_count;
    logic [LAT_W-1:0]  inflight;

    word_t                          mem [2**ADDR_WIDTH];
    word_t                          rd_q [COMMON_BRAM_LATENCY];
    logic [COMMON_BRAM_LATENCY-1:0] rd_v;
    logic [COMMON_BRAM_LATENCY-1:0] rd_last;

    always_comb begin
        if (32'(i_n) >= ADDR_WIDTH) n_req = CNT_W'(1) << ADDR_WIDTH;
        else                        n_req = CNT_W'(1) << i_n;
    end

    // A write in the same IDLE cycle as i_start belongs to the new fill, so
    // range and count checks there use the size being requested.
    assign n_eff     = (state == IDLE) ? n_req : n_lat;
    assign wcnt_inc  = ((state == IDLE) ? '0 : wcnt) + 1'b1;
    assign addr_ok   = ({1'b0, i_addr_rb} < n_eff);
    assign wr_en     = i_we_rb & addr_ok & ((state == FILL) | ((state == IDLE) & i_start));
    assign fill_full = wr_en & (wcnt_inc == n_eff);
    assign err_next  = (i_start & (state != IDLE)) | (i_we_rb & ~wr_en);
    assign beat_last = o_valid & i_ready & o_last;
    assign o_err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = fill_full ? DRAIN : FILL;
            FILL:    if (fill_full) state_nxt = DRAIN;
            DRAIN:   if (beat_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        rd_en  = 1'b0;
        case (state)
            FILL:  o_busy = 1'b1;
            DRAIN: begin
                o_busy = 1'b1;
                // Credit check counts reads still in the BRAM pipe so the
                // FIFO can never be pushed while full.
                rd_en  = (rptr < n_lat) &&
                         ((32'(fifo_count) + 32'(inflight)) < DEPTH);
            end
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lat <= '0;
            wcnt  <= '0;
            rptr  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_next;
            if ((state == IDLE) && i_start) n_lat <= n_req;
            if (wr_en)                               wcnt <= wcnt_inc;
            else if ((state == IDLE) && i_start)     wcnt <= '0;
            if (state != DRAIN) rptr <= '0;
            else if (rd_en)     rptr <= rptr + 1'b1;
        end
    end

    // Simple dual-port buffer; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[i_addr_rb] <= i_data_rb;
        if (rd_en) rd_q[0] <= mem[rptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 1; k < COMMON_BRAM_LATENCY; k++) begin
            rd_q[k] <= rd_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_v    <= '0;
            rd_last <= '0;
        end else begin
            rd_v[0]    <= rd_en;
            rd_last[0] <= rd_en & (rptr == n_lat - 1'b1);
            for (int unsigned k = 1; k < COMMON_BRAM_LATENCY; k++) begin
                rd_v[k]    <= rd_v[k-1];
                rd_last[k] <= rd_last[k-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < COMMON_BRAM_LATENCY; k++) begin
            inflight = inflight + LAT_W'(rd_v[k]);
        end
    end

    rb_skid_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (rd_v[COMMON_BRAM_LATENCY-1]),
        .i_data  (rd_q[COMMON_BRAM_LATENCY-1]),
        .i_last  (rd_last[COMMON_BRAM_LATENCY-1]),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_valid (o_valid),
        .o_count (fifo_count)
    );

endmodule

// File: tb/tb_reduce_buffer_drain.sv
module tb_reduce_buffer_drain;
    import addx_pkg::*;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 12;
    localparam int unsigned LAT = 1;

    logic                   clk = 1'b0;
    logic                   rst_n, i_start, i_we_rb, i_ready;
    logic [LEVEL_WIDTH-1:0] i_n;
    poly_word_t             i_data_rb, o_data;
    logic [AW-1:0]          i_addr_rb;
    logic                   o_valid, o_last, o_busy, o_done, o_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] got_d0[$];
    logic [DW-1:0] got_d1[$];
    bit            got_last[$];
    int            first_idx, done_idx, stall_bad, err_cnt;
    bit            timed_out;

    reduce_buffer_drain #(
        .DATA_WIDTH          (DW),
        .ADDR_WIDTH          (AW),
        .COMMON_BRAM_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_n       (i_n),
        .i_data_rb (i_data_rb),
        .i_addr_rb (i_addr_rb),
        .i_we_rb   (i_we_rb),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_last    (o_last),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input int n);
        i_n     = LEVEL_WIDTH'(n);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        i_we_rb      = 1'b1;
        i_addr_rb    = AW'(a);
        i_data_rb[0] = d0;
        i_data_rb[1] = d1;
        step();
        i_we_rb = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
    // max_beats > 0 stops after that many beats; inject_at drives i_start and
    // a write to inject_addr for one cycle at that index.
    task automatic collect(input int mode, input int max_beats, input int inject_at,
                           input int inject_addr, input int budget);
        bit         prev_stall;
        poly_word_t prev_data;
        got_d0.delete();
        got_d1.delete();
        got_last.delete();
        first_idx  = -1;
        done_idx   = -1;
        stall_bad  = 0;
        err_cnt    = 0;
        timed_out  = 1'b1;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int k = 0; k < budget; k++) begin
            i_ready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            if (k == inject_at) begin
                i_start   = 1'b1;
                i_we_rb   = 1'b1;
                i_addr_rb = AW'(inject_addr);
                i_data_rb = '1;
            end else begin
                i_start = 1'b0;
                i_we_rb = 1'b0;
            end
            if (o_err) err_cnt++;
            if (o_done) begin
                done_idx  = k;
                timed_out = 1'b0;
                break;
            end
            if (o_valid && first_idx < 0) first_idx = k;
            if (prev_stall && (!o_valid || o_data !== prev_data)) stall_bad++;
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            if (o_valid && i_ready) begin
                got_d0.push_back(o_data[0]);
                got_d1.push_back(o_data[1]);
                got_last.push_back(o_last);
            end
            step();
            if (max_beats > 0 && got_d0.size() >= max_beats) begin
                timed_out = 1'b0;
                break;
            end
        end
        i_start = 1'b0;
        i_we_rb = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_we_rb = 1'b0; i_ready = 1'b0;
        i_n = '0; i_addr_rb = '0; i_data_rb = '0;
        step();
        step();
        n_checks++;
        if (o_data !== '0) $display("FAIL reset_data: got %h want 0", o_data); else n_pass++;
        n_checks++;
        if ({o_valid, o_last, o_busy, o_done, o_err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {o_valid, o_last, o_busy, o_done, o_err});
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int bad_d, bad_l;
        start_fill(3);
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", o_busy); else n_pass++;
        for (int a = 7; a >= 0; a--) do_write(a, DW'(a), DW'(a + 100));
        collect(0, 0, -1, 0, 100);
        bad_d = 0; bad_l = 0;
        for (int i = 0; i < got_d0.size(); i++) begin
            if (got_d0[i] !== DW'(i) || got_d1[i] !== DW'(i + 100)) bad_d++;
            if (got_last[i] !== (i == 7)) bad_l++;
        end
        n_checks++;
        if (timed_out) $display("FAIL basic_timeout: got no o_done want o_done"); else n_pass++;
        n_checks++;
        if (first_idx != 2) $display("FAIL basic_first_valid: got %0d want 2", first_idx); else n_pass++;
        n_checks++;
        if (got_d0.size() != 8) $display("FAIL basic_beats: got %0d want 8", got_d0.size()); else n_pass++;
        n_checks++;
        if (bad_d != 0) $display("FAIL basic_data: got %0d bad beats want 0", bad_d); else n_pass++;
        n_checks++;
        if (bad_l != 0) $display("FAIL basic_last: got %0d bad flags want 0", bad_l); else n_pass++;
        n_checks++;
        if (done_idx != 10) $display("FAIL basic_done_time: got %0d want 10", done_idx); else n_pass++;
        step();
        n_checks++;
        if ({o_busy, o_done} !== 2'b00) $display("FAIL basic_idle: got %b want 00", {o_busy, o_done});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad_d, bad_l;
        start_fill(4);
        for (int a = 0; a < 16; a++) do_write(a, DW'(64'hB000 + a * 3), DW'(64'hC000 + a));
        collect(1, 0, -1, 0, 300);
        bad_d = 0; bad_l = 0;
        for (int i = 0; i < got_d0.size(); i++) begin
            if (got_d0[i] !== DW'(64'hB000 + i * 3) || got_d1[i] !== DW'(64'hC000 + i)) bad_d++;
            if (got_last[i] !== (i == 15)) bad_l++;
        end
        n_checks++;
        if (timed_out || got_d0.size() != 16)
            $display("FAIL bp_beats: got %0d beats timeout=%0d want 16 beats", got_d0.size(), timed_out);
        else n_pass++;
        n_checks++;
        if (bad_d != 0) $display("FAIL bp_data: got %0d bad beats want 0", bad_d); else n_pass++;
        n_checks++;
        if (bad_l != 0) $display("FAIL bp_last: got %0d bad flags want 0", bad_l); else n_pass++;
        n_checks++;
        if (stall_bad != 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); else n_pass++;
        n_checks++;
        if (err_cnt != 0) $display("FAIL bp_err: got %0d pulses want 0", err_cnt); else n_pass++;
        step();
    endtask

    task automatic test_errors();
        int saw_valid, bad_d;
        do_write(1, DW'(64'hDEAD), DW'(64'hBEEF));
        n_checks++;
        if ({o_err, o_busy} !== 2'b10) $display("FAIL err_idle_write: got %b want 10", {o_err, o_busy});
        else n_pass++;
        step();
        n_checks++;
        if (o_err !== 1'b0) $display("FAIL err_one_shot: got %b want 0", o_err); else n_pass++;
        start_fill(2);
        do_write(5, DW'(64'h1), DW'(64'h2));
        n_checks++;
        if (o_err !== 1'b1) $display("FAIL err_addr_range: got %b want 1", o_err); else n_pass++;
        for (int a = 0; a < 3; a++) do_write(a, DW'(64'h40 + a), DW'(64'h50 + a));
        saw_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_valid || !o_busy) saw_valid++;
            step();
        end
        n_checks++;
        if (saw_valid != 0) $display("FAIL err_fill_incomplete: got %0d early cycles want 0", saw_valid);
        else n_pass++;
        do_write(3, DW'(64'h43), DW'(64'h53));
        collect(0, 0, -1, 0, 100);
        bad_d = 0;
        for (int i = 0; i < got_d0.size(); i++)
            if (got_d0[i] !== DW'(64'h40 + i) || got_d1[i] !== DW'(64'h50 + i)) bad_d++;
        n_checks++;
        if (timed_out || got_d0.size() != 4 || bad_d != 0)
            $display("FAIL err_drain: got %0d beats %0d bad want 4 beats 0 bad", got_d0.size(), bad_d);
        else n_pass++;
        step();
    endtask

    task automatic test_edge_sizes();
        int bad_d, bad_l;
        i_n = '0; i_start = 1'b1; i_we_rb = 1'b1; i_addr_rb = '0;
        i_data_rb[0] = DW'(64'h55); i_data_rb[1] = DW'(64'h66);
        step();
        i_start = 1'b0; i_we_rb = 1'b0;
        collect(0, 0, -1, 0, 50);
        n_checks++;
        if (first_idx != 2 || got_d0.size() != 1)
            $display("FAIL n0_beats: got first=%0d beats=%0d want first=2 beats=1", first_idx, got_d0.size());
        else n_pass++;
        n_checks++;
        if (got_d0.size() != 1 || got_d0[0] !== DW'(64'h55) || got_d1[0] !== DW'(64'h66) || got_last[0] !== 1'b1)
            $display("FAIL n0_data: got beats=%0d want one beat 55/66 last=1", got_d0.size());
        else n_pass++;
        step();
        start_fill(15);
        for (int a = 0; a < 4096; a++) do_write(a, DW'(a), DW'(a ^ 'hFFF));
        collect(0, 0, -1, 0, 5000);
        bad_d = 0; bad_l = 0;
        for (int i = 0; i < got_d0.size(); i++) begin
            if (got_d0[i] !== DW'(i) || got_d1[i] !== DW'(i ^ 'hFFF)) bad_d++;
            if (got_last[i] !== (i == 4095)) bad_l++;
        end
        n_checks++;
        if (got_d0.size() != 4096) $display("FAIL n15_beats: got %0d want 4096", got_d0.size()); else n_pass++;
        n_checks++;
        if (bad_d != 0 || bad_l != 0)
            $display("FAIL n15_data: got %0d bad data %0d bad last want 0 0", bad_d, bad_l);
        else n_pass++;
        n_checks++;
        if (done_idx != 4098) $display("FAIL n15_done_time: got %0d want 4098", done_idx); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_drain();
        int idle_bad, bad_d;
        start_fill(3);
        for (int a = 0; a < 8; a++) do_write(a, DW'(64'h300 + a), DW'(64'h400 + a));
        collect(0, 2, -1, 0, 100);
        n_checks++;
        if (got_d0.size() != 2) $display("FAIL rst_pre_beats: got %0d want 2", got_d0.size()); else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (o_data !== '0 || {o_valid, o_last, o_busy, o_done, o_err} !== 5'b0)
            $display("FAIL rst_mid_outputs: got %b data %h want 00000 data 0",
                     {o_valid, o_last, o_busy, o_done, o_err}, o_data);
        else n_pass++;
        step();
        rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_done || o_busy || o_valid) idle_bad++;
            step();
        end
        n_checks++;
        if (idle_bad != 0) $display("FAIL rst_no_done: got %0d active cycles want 0", idle_bad); else n_pass++;
        start_fill(1);
        do_write(1, DW'(64'h901), DW'(64'h911));
        do_write(0, DW'(64'h900), DW'(64'h910));
        collect(0, 0, -1, 0, 100);
        bad_d = 0;
        for (int i = 0; i < got_d0.size(); i++)
            if (got_d0[i] !== DW'(64'h900 + i) || got_d1[i] !== DW'(64'h910 + i) || got_last[i] !== (i == 1))
                bad_d++;
        n_checks++;
        if (got_d0.size() != 2 || bad_d != 0 || done_idx != 4)
            $display("FAIL rst_rerun: got %0d beats %0d bad done@%0d want 2 beats 0 bad done@4",
                     got_d0.size(), bad_d, done_idx);
        else n_pass++;
        step();
    endtask

    task automatic test_protocol();
        int bad_d;
        start_fill(2);
        for (int a = 0; a < 4; a++) do_write(a, DW'(64'h700 + a), DW'(64'h800 + a));
        collect(0, 0, 0, 3, 100);
        bad_d = 0;
        for (int i = 0; i < got_d0.size(); i++)
            if (got_d0[i] !== DW'(64'h700 + i) || got_d1[i] !== DW'(64'h800 + i)) bad_d++;
        n_checks++;
        if (err_cnt != 1) $display("FAIL proto_err: got %0d pulses want 1", err_cnt); else n_pass++;
        n_checks++;
        if (timed_out || got_d0.size() != 4 || bad_d != 0)
            $display("FAIL proto_data: got %0d beats %0d bad want 4 beats 0 bad", got_d0.size(), bad_d);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_edge_sizes();
        test_reset_mid_drain();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
